// File: rtl/insn_encoder.sv
`default_nettype none
// ============================================================================
// Module      : insn_encoder
// Description : Packs instruction fields into a single instruction word,
//               checks the immediate against the range its opcode class can
//               hold, and presents accepted words through a two-entry skid
//               buffer with registered valid/ready handshakes.
//               Rejected field sets are consumed, flagged with a one-cycle
//               err_o pulse and counted in a saturating 8-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module insn_encoder #(
    parameter int LEN_INSN      = 32,
    parameter int LEN_OPECODE   = 7,
    parameter int SHIFT_OPECODE = 25,
    parameter int LEN_IMMF      = 1,
    parameter int SHIFT_IMMF    = 24,
    parameter int LEN_REGNO     = 6,
    parameter int SHIFT_RD      = 18,
    parameter int SHIFT_RS      = 12,
    parameter int LEN_CC        = 4,
    parameter int SHIFT_CC      = 8,
    parameter int LEN_IMM       = 8,
    parameter int SHIFT_IMM     = 0,
    parameter int LEN_IMM_EX    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LEN_OPECODE-1:0] opecode_i,
    input  logic [LEN_IMMF-1:0]    immf_i,
    input  logic [LEN_REGNO-1:0]   rd_i,
    input  logic [LEN_REGNO-1:0]   rs_i,
    input  logic [LEN_CC-1:0]      cc_i,
    input  logic [LEN_IMM_EX-1:0]  imm_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LEN_INSN-1:0]    insn_o,
    output logic                   err_o,
    output logic [7:0]             err_cnt_o
);

    // Width of the zero-extended immediate used by the 000_1xxx opcode class.
    localparam int C_IMM_NARROW = 5;

    // Opcode class codes taken from the top four opcode bits.
    localparam logic [3:0] C_GRP_SEXT_A = 4'b0000;
    localparam logic [3:0] C_GRP_NARROW = 4'b0001;
    localparam logic [3:0] C_GRP_SEXT_B = 4'b0011;

    // Buffer occupancy: EMPTY (main invalid), ONE (main only), FULL (main+skid).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LEN_INSN-1:0]   main_q, main_d;
    logic [LEN_INSN-1:0]   skid_q, skid_d;
    logic                  in_ready_q, in_ready_d;
    logic                  err_q, err_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic [3:0]            w_opc_grp;
    logic [LEN_IMM-1:0]    w_imm_field;
    logic                  w_imm_legal;
    logic [LEN_INSN-1:0]   w_enc_word;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_accept;
    logic                  w_reject;

    assign w_opc_grp  = opecode_i[LEN_OPECODE-1 -: 4];
    assign w_in_fire  = in_valid & in_ready_q;
    assign w_out_fire = out_valid & out_ready;
    assign w_accept   = w_in_fire & w_imm_legal;
    assign w_reject   = w_in_fire & ~w_imm_legal;

    // Select the immediate field and decide whether imm_i fits the opcode class.
    always_comb begin
        w_imm_field = '0;
        w_imm_legal = 1'b1;
        if (immf_i != '0) begin
            if ((w_opc_grp == C_GRP_SEXT_A) || (w_opc_grp == C_GRP_SEXT_B)) begin
                // Signed 8-bit: every bit from the field sign upward must match.
                w_imm_field = imm_i[LEN_IMM-1:0];
                w_imm_legal = (&imm_i[LEN_IMM_EX-1:LEN_IMM-1]) |
                              ~(|imm_i[LEN_IMM_EX-1:LEN_IMM-1]);
            end else if (w_opc_grp == C_GRP_NARROW) begin
                // Unsigned 5-bit, zero-extended into the field.
                w_imm_field[C_IMM_NARROW-1:0] = imm_i[C_IMM_NARROW-1:0];
                w_imm_legal = ~(|imm_i[LEN_IMM_EX-1:C_IMM_NARROW]);
            end else begin
                // Unsigned 8-bit.
                w_imm_field = imm_i[LEN_IMM-1:0];
                w_imm_legal = ~(|imm_i[LEN_IMM_EX-1:LEN_IMM]);
            end
        end
    end

    // Place every field at its bit position; uncovered bits stay zero.
    always_comb begin
        w_enc_word = '0;
        w_enc_word[SHIFT_OPECODE +: LEN_OPECODE] = opecode_i;
        w_enc_word[SHIFT_IMMF    +: LEN_IMMF]    = immf_i;
        w_enc_word[SHIFT_RD      +: LEN_REGNO]   = rd_i;
        w_enc_word[SHIFT_RS      +: LEN_REGNO]   = rs_i;
        w_enc_word[SHIFT_CC      +: LEN_CC]      = cc_i;
        w_enc_word[SHIFT_IMM     +: LEN_IMM]     = w_imm_field;
    end

    // Next-state logic for the skid buffer, ready flag and error reporting.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    main_d  = w_enc_word;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_out_fire) begin
                    // Main drains and refills on the same edge; stays ONE.
                    main_d = w_enc_word;
                end else if (w_accept) begin
                    skid_d  = w_enc_word;
                    state_d = ST_FULL;
                end else if (w_out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    main_d = skid_q;
                    // in_ready is low while FULL, so an accept here cannot
                    // normally coincide; if it did, it would refill the skid.
                    if (w_accept) begin
                        skid_d = w_enc_word;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        in_ready_d = (state_d != ST_FULL);
        err_d      = w_reject;
        err_cnt_d  = err_cnt_q;
        if (w_reject && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State registers; reset discards any buffered word and holds in_ready low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign insn_o    = main_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_insn_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_insn_encoder
// Description : Self-checking bench for insn_encoder. A queue-based model
//               tracks accepted words in order, the error pulse and count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_insn_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opecode_i;
    logic [0:0]  immf_i;
    logic [5:0]  rd_i;
    logic [5:0]  rs_i;
    logic [3:0]  cc_i;
    logic [31:0] imm_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] insn_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    int checks   = 0;
    int failures = 0;

    // Model state: words waiting at the output, in arrival order.
    logic [31:0] m_q[$];
    bit          m_ready;
    bit          m_err;
    int          m_cnt;

    always #5 clk = ~clk;

    insn_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opecode_i (opecode_i),
        .immf_i    (immf_i),
        .rd_i      (rd_i),
        .rs_i      (rs_i),
        .cc_i      (cc_i),
        .imm_i     (imm_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .insn_o    (insn_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
    );

    // Is the immediate representable for this opcode class?
    function automatic bit m_legal(logic [6:0] opc, logic [0:0] immf, logic [31:0] imm);
        int grp;
        int s;
        if (immf == 1'b0) return 1'b1;
        grp = int'(opc) / 8;
        s   = $signed(imm);
        if (grp == 0 || grp == 3) return (s >= -128 && s <= 127);
        if (grp == 1) return (imm < 32);
        return (imm < 256);
    endfunction

    // Arithmetic packing of a legal field set.
    function automatic logic [31:0] m_word(logic [6:0] opc, logic [0:0] immf, logic [5:0] rd,
                                           logic [5:0] rs, logic [3:0] cc, logic [31:0] imm);
        longint w;
        longint iv;
        iv = (immf == 1'b1) ? longint'(imm % 256) : 0;
        w  = longint'(opc) * (2**25) + longint'(immf) * (2**24) + longint'(rd) * (2**18)
           + longint'(rs) * (2**12) + longint'(cc) * (2**8) + iv;
        return w[31:0];
    endfunction

    function automatic logic [31:0] m_head();
        return (m_q.size() > 0) ? m_q[0] : 32'h0;
    endfunction

    // Advance one clock and update the model from the handshakes of that cycle.
    task automatic step();
        bit          inf;
        bit          outf;
        logic [31:0] dropped;
        inf  = in_valid && m_ready;
        outf = out_ready && (m_q.size() > 0);
        @(posedge clk);
        #1;
        if (outf) dropped = m_q.pop_front();
        m_err = 1'b0;
        if (inf) begin
            if (m_legal(opecode_i, immf_i, imm_i))
                m_q.push_back(m_word(opecode_i, immf_i, rd_i, rs_i, cc_i, imm_i));
            else begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        m_ready = (m_q.size() < 2);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ready = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic set_fields(logic [6:0] opc, logic [0:0] immf, logic [5:0] rd,
                              logic [5:0] rs, logic [3:0] cc, logic [31:0] imm);
        opecode_i = opc;
        immf_i    = immf;
        rd_i      = rd;
        rs_i      = rs;
        cc_i      = cc;
        imm_i     = imm;
    endtask

    task automatic rand_fields();
        int sel;
        opecode_i = 7'($urandom);
        immf_i    = 1'($urandom);
        rd_i      = 6'($urandom);
        rs_i      = 6'($urandom);
        cc_i      = 4'($urandom);
        sel       = $urandom_range(0, 3);
        case (sel)
            0:       imm_i = $urandom_range(0, 40);
            1:       imm_i = $urandom_range(0, 300);
            2:       imm_i = 32'd0 - $urandom_range(1, 130);
            default: imm_i = $urandom;
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_fields(7'h0, 1'b0, 6'h0, 6'h0, 4'h0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || err_o !== 1'b0 ||
            err_cnt_o !== 8'd0 || insn_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_values out_valid=%b in_ready=%b err=%b cnt=%0d insn=%h expected all zero",
                     out_valid, in_ready, err_o, err_cnt_o, insn_o);
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic_pack();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_fields(7'h01, 1'b1, 6'd3, 6'd5, 4'd2, 32'hFFFF_FFFE);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || insn_o !== 32'h030C_52FE || err_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_pack out_valid=%b insn=%h err=%b expected 1 030c52fe 0",
                     out_valid, insn_o, err_o);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_drain out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_range_error();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_fields(7'h08, 1'b1, 6'd1, 6'd2, 4'd3, 32'h20);
        step();
        in_valid = 1'b0;
        checks++;
        if (err_o !== 1'b1 || out_valid !== 1'b0 || err_cnt_o !== 8'd1) begin
            failures++;
            $display("FAIL range_err err=%b out_valid=%b cnt=%0d expected 1 0 1", err_o, out_valid, err_cnt_o);
        end
        step();
        checks++;
        if (err_o !== 1'b0 || err_cnt_o !== 8'd1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL range_err_pulse err=%b cnt=%0d out_valid=%b expected 0 1 0", err_o, err_cnt_o, out_valid);
        end
        in_valid = 1'b1;
        set_fields(7'h08, 1'b1, 6'd1, 6'd2, 4'd3, 32'h1F);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || insn_o !== 32'h1104_231F || err_o !== 1'b0) begin
            failures++;
            $display("FAIL range_next_legal out_valid=%b insn=%h err=%b expected 1 1104231f 0",
                     out_valid, insn_o, err_o);
        end
        step();
    endtask

    task automatic test_immf_zero();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_fields(7'h45, 1'b0, 6'd10, 6'd20, 4'd9, 32'hDEAD_BEEF);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || err_o !== 1'b0 || insn_o[7:0] !== 8'h00 ||
            insn_o !== m_head() || err_cnt_o !== m_cnt[7:0]) begin
            failures++;
            $display("FAIL immf_zero out_valid=%b err=%b insn=%h cnt=%0d expected 1 0 %h %0d",
                     out_valid, err_o, insn_o, err_cnt_o, m_head(), m_cnt);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w[3];
        logic [6:0]  opcs[3];
        opcs[0] = 7'h20;
        opcs[1] = 7'h18;
        opcs[2] = 7'h7F;
        for (int k = 0; k < 3; k++)
            exp_w[k] = m_word(opcs[k], 1'b1, 6'(k + 1), 6'(k + 7), 4'(k), 32'(k + 100));
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            set_fields(opcs[k], 1'b1, 6'(k + 1), 6'(k + 7), 4'(k), 32'(k + 100));
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || insn_o !== exp_w[0] || m_q.size() != 2) begin
            failures++;
            $display("FAIL bp_full in_ready=%b out_valid=%b insn=%h expected 0 1 %h",
                     in_ready, out_valid, insn_o, exp_w[0]);
        end
        step();
        checks++;
        if (insn_o !== exp_w[0] || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_stable insn=%h out_valid=%b expected %h 1", insn_o, out_valid, exp_w[0]);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (insn_o !== exp_w[1] || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_second insn=%h out_valid=%b in_ready=%b expected %h 1 1",
                     insn_o, out_valid, in_ready, exp_w[1]);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_drained out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rand_fields();
            step();
            checks++;
            if (in_ready !== m_ready || out_valid !== (m_q.size() > 0) || err_o !== m_err ||
                err_cnt_o !== m_cnt[7:0] || (m_q.size() > 0 && insn_o !== m_head())) begin
                failures++;
                $display("FAIL random cyc=%0d in_ready=%b/%b out_valid=%b/%b err=%b/%b cnt=%0d/%0d insn=%h/%h (got/expected)",
                         cyc, in_ready, m_ready, out_valid, (m_q.size() > 0), err_o, m_err,
                         err_cnt_o, m_cnt, insn_o, m_head());
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_saturation();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        set_fields(7'h08, 1'b1, 6'd0, 6'd0, 4'd0, 32'h20);
        for (int i = 0; i < 300; i++) begin
            step();
            if (m_cnt == 255 || i == 299) begin
                checks++;
                if (err_cnt_o !== m_cnt[7:0] || err_o !== 1'b1 || out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL saturation i=%0d cnt=%0d err=%b out_valid=%b expected %0d 1 0",
                             i, err_cnt_o, err_o, out_valid, m_cnt);
                end
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (err_cnt_o !== 8'd255 || err_o !== 1'b0) begin
            failures++;
            $display("FAIL saturation_hold cnt=%0d err=%b expected 255 0", err_cnt_o, err_o);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            set_fields(7'h30, 1'b1, 6'(k), 6'(k), 4'(k), 32'(k + 1));
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_full out_valid=%b in_ready=%b expected 1 0", out_valid, in_ready);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || insn_o !== 32'h0 || err_cnt_o !== 8'd0) begin
            failures++;
            $display("FAIL midreset_async out_valid=%b in_ready=%b insn=%h cnt=%0d expected 0 0 0 0",
                     out_valid, in_ready, insn_o, err_cnt_o);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL midreset_stale i=%0d out_valid=%b in_ready=%b expected 0 1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_pack();
        test_range_error();
        test_immf_zero();
        test_backpressure();
        test_random();
        test_saturation();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
